// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and widths for controlador_codificador; CTRL_PARITY_EN adds an even-parity frame bit
package ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, SHIFT} state_t;
  localparam int CODE_W = 5;
`ifdef CTRL_PARITY_EN
  localparam int FRAME_W = CODE_W + 1;
`else
  localparam int FRAME_W = CODE_W;
`endif
  localparam int CNT_W = 3;
endpackage

// File: rtl/controlador_codificador_rr_arbiter2.sv
// rr_arbiter2: two-port round-robin grant, favouring the port not granted last
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  assign gnt = {req[1] & (~req[0] | ~last), req[0] & (~req[1] | last)};
endmodule

// File: rtl/controlador_codificador.sv
// controlador_codificador: arbitrates two nibble requesters onto the shared encoder and serialises its code (CTRL_PARITY_EN adds parity)
module controlador_codificador
  import ctrl_pkg::*;
#(
  parameter int ENC_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [3:0] nib0,
  output logic       ack0,
  input  logic       req1,
  input  logic [3:0] nib1,
  output logic       ack1,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       ready,
  input  logic       m1,
  input  logic       m2,
  input  logic       m3,
  input  logic       m4,
  input  logic       m5,
  output logic       tx_bit,
  output logic       tx_valid,
  output logic       tx_src,
  output logic       busy
);
  state_t             state;
  logic               last;
  logic               src;
  logic [3:0]         nib_q;
  logic [FRAME_W-1:0] sr;
  logic [FRAME_W-1:0] frame;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         gnt;
  rr_arbiter2 u_arb (
    .req ({req1, req0}),
    .last(last),
    .gnt (gnt)
  );
`ifdef CTRL_PARITY_EN
  assign frame = {m1, m2, m3, m4, m5, m1 ^ m2 ^ m3 ^ m4 ^ m5};
`else
  assign frame = {m1, m2, m3, m4, m5};
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
      src   <= 1'b0;
      nib_q <= 4'd0;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (|gnt) begin
          state <= ISSUE;
          src   <= gnt[1];
          last  <= gnt[1];
          nib_q <= gnt[1] ? nib1 : nib0;
        end
        ISSUE: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: if (cnt == CNT_W'(ENC_LAT - 1)) begin
          state <= SHIFT;
          sr    <= frame;
          cnt   <= '0;
        end else cnt <= cnt + 1'b1;
        SHIFT: begin
          sr  <= sr << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(FRAME_W - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign ready        = state == ISSUE;
  assign ack0         = ready & ~src;
  assign ack1         = ready & src;
  assign {a, b, c, d} = (state == ISSUE || state == WAIT) ? nib_q : 4'd0;
  assign tx_valid     = state == SHIFT;
  assign tx_bit       = sr[FRAME_W-1];
  assign tx_src       = src;
  assign busy         = state != IDLE;
endmodule

// File: tb/tb_controlador_codificador.sv
// tb_controlador_codificador: table-driven check of arbitration, encoder handshake and serial framing
module tb_controlador_codificador;
  localparam int ENC_LAT = 1;
`ifdef CTRL_PARITY_EN
  localparam int FW = 6;
`else
  localparam int FW = 5;
`endif
  typedef struct packed {
    logic       r0;
    logic [3:0] n0;
    logic       r1;
    logic [3:0] n1;
    logic       src;
    logic [4:0] code;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, req0 = 1'b0, req1 = 1'b0;
  logic [3:0] nib0 = 4'd0, nib1 = 4'd0;
  logic a, b, c, d, ready, ack0, ack1, tx_bit, tx_valid, tx_src, busy;
  logic m1 = 1'b0, m2 = 1'b0, m3 = 1'b0, m4 = 1'b0, m5 = 1'b0;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  vec_t tv[20];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ready) {m1, m2, m3, m4, m5} <= {1'b1, a, b, c, d};
  controlador_codificador #(.ENC_LAT(ENC_LAT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .nib0(nib0), .ack0(ack0),
    .req1(req1), .nib1(nib1), .ack1(ack1),
    .a(a), .b(b), .c(c), .d(d), .ready(ready),
    .m1(m1), .m2(m2), .m3(m3), .m4(m4), .m5(m5),
    .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_src(tx_src), .busy(busy)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic logic [FW-1:0] exp_frame(input logic [4:0] code);
`ifdef CTRL_PARITY_EN
    return {code, ^code};
`else
    return code;
`endif
  endfunction
  task automatic run(input vec_t v);
    logic [FW-1:0] got;
    int k;
    req0 = v.r0; nib0 = v.n0; req1 = v.r1; nib1 = v.n1;
    @(negedge clk);
    chk("ack", {ack1, ack0}, v.src ? 2 : 1);
    chk("ready", ready, 1);
    chk("abcd", {a, b, c, d}, v.src ? v.n1 : v.n0);
    if (v.src) req1 = 1'b0; else req0 = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!tx_valid && k < 20);
    chk("first_bit_lat", k, ENC_LAT + 1);
    got = '0;
    for (int i = 0; i < FW; i++) begin
      chk("tx_valid", tx_valid, 1);
      chk("tx_src", tx_src, v.src);
      chk("ack_vs_tx", {ack1, ack0}, 0);
      got = {got[FW-2:0], tx_bit};
      @(negedge clk);
    end
    chk("frame", got, exp_frame(v.code));
    chk("valid_end", tx_valid, 0);
    chk("busy_end", busy, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [3:0] nibs [4];
    int t [4];
    int k;
    nibs = '{4'h9, 4'h6, 4'hF, 4'h0};
    tv[0] = '{1'b1, 4'b0001, 1'b1, 4'b1110, 1'b0, 5'b10001};
    tv[1] = '{1'b1, 4'b0001, 1'b1, 4'b1110, 1'b1, 5'b11110};
    tv[2] = '{1'b1, 4'b0001, 1'b1, 4'b1110, 1'b0, 5'b10001};
    tv[3] = '{1'b1, 4'b0101, 1'b0, 4'b0000, 1'b0, 5'b10101};
    for (int i = 0; i < 16; i++) tv[4+i] = '{1'b1, 4'(i), 1'b0, 4'd0, 1'b0, {1'b1, 4'(i)}};
    @(negedge clk);
    @(negedge clk);
    chk("reset_outs", {ack0, ack1, a, b, c, d, ready, tx_bit, tx_valid, tx_src, busy}, 0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) run(tv[i]);
    req1 = 1'b1; nib1 = nibs[0];
    for (int j = 0; j < 4; j++) begin
      k = 0;
      do begin @(negedge clk); k++; end while (!ack1 && k < 20);
      if (j == 0) chk("b2b_first_lat", k, 1);
      chk("b2b_ack", ack1, 1);
      chk("b2b_no_tx", tx_valid, 0);
      chk("b2b_abcd", {a, b, c, d}, nibs[j]);
      t[j] = cyc;
      if (j > 0) chk("b2b_period", t[j] - t[j-1], 7 + ENC_LAT);
      if (j == 3) req1 = 1'b0; else nib1 = nibs[j+1];
    end
    k = 0;
    do begin @(negedge clk); k++; end while (busy && k < 40);
    chk("b2b_idle", busy, 0);
    req0 = 1'b1; nib0 = 4'b0101;
    @(negedge clk);
    chk("rst_pre_ack", ack0, 1);
    req0 = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!tx_valid && k < 20);
    @(negedge clk);
    @(negedge clk);
    chk("rst_third_bit", tx_valid, 1);
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; nib0 = 4'b0011; nib1 = 4'b1100;
    @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_all_outs", {ack0, ack1, a, b, c, d, ready, tx_bit, tx_valid, tx_src, busy}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_grant", {ack1, ack0}, 1);
    chk("post_rst_abcd", {a, b, c, d}, 4'b0011);
    req0 = 1'b0; req1 = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (busy && k < 40);
    chk("post_rst_idle", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/controlador_codificador.md
# controlador_codificador

Sequencer and two-port arbiter for the shared 4-bit → 5-bit combinational encoder (`codificador`). It accepts nibbles from two requesters and grants them round-robin. For each granted nibble it drives the encoder inputs `a..d` and pulses `ready`, then captures `m1..m5` and serialises them, one bit per clock, onto a single output line. It sits between the nibble producers and the serial line driver.

## Interface
Parameters:
- `ENC_LAT`, default 1: cycles waited after the `ready` pulse before sampling `m1..m5`. Legal range is 1..7.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `req0`, input, 1: requester 0 has a nibble; held until acknowledged.
- `nib0`, input, 4: requester 0 data; must stay stable while `req0` is high.
- `ack0`, output, 1: one-cycle pulse; `nib0` has been consumed.
- `req1`, `nib1`, `ack1`: same signals for requester 1.
- `a`, `b`, `c`, `d`, output, 1 each: encoder inputs; `a` = nib[3], `d` = nib[0].
- `ready`, output, 1: one-cycle strobe to the encoder.
- `m1`..`m5`, input, 1 each: encoder outputs.
- `tx_bit`, output, 1: serial data, `m1` first.
- `tx_valid`, output, 1: high while `tx_bit` carries a code bit.
- `tx_src`, output, 1: requester id of the code currently shifting.
- `busy`, output, 1: high in every state except IDLE.

## Operation
- States:
  - IDLE: wait for a request.
  - ISSUE: one cycle; drive `a..d` with the granted nibble, assert `ready`, pulse `ack` of the granted port.
  - WAIT: `ENC_LAT` cycles; hold `a..d`.
  - SHIFT: one cycle per frame bit.
- Transitions:
  - IDLE → ISSUE when `req0 | req1` is sampled high.
  - ISSUE → WAIT.
  - WAIT → SHIFT after `ENC_LAT` cycles; `m1..m5` are latched into a 5-bit shift register on the last WAIT cycle.
  - SHIFT → IDLE after the last frame bit.
- Arbitration:
  - Round-robin with a 1-bit last-grant pointer; reset value 1, so requester 0 wins first.
  - When both requests are high, the port that was not granted last wins.
  - A single request always wins.
  - Requests are evaluated only in IDLE and ignored in other states.
- Nibble latching: the granted nibble is latched at the IDLE → ISSUE edge. `a..d` come from that register, so requesters may change `nib` after `ack`.
- Outputs outside ISSUE/WAIT: `a..d` are 0. `ready`, `ack0`, `ack1` are high only in ISSUE.
- Frame length is 5 bits (6 bits with parity, see Configuration). `tx_valid` is high for exactly that many consecutive cycles per grant.
- Reset values: all outputs 0, state IDLE, pointer 1, shift register 0.
- Reset in any state, including mid-SHIFT:
  - abort the frame; `tx_valid` drops the next cycle;
  - no `ack` is issued;
  - an un-acked requester keeps its request and is served after reset.

## Timing
- `req` sampled high at edge t:
  - ISSUE (`ack`, `ready`) during cycle t+1;
  - first `tx_valid` bit at cycle t+2+`ENC_LAT`;
  - last bit at t+6+`ENC_LAT` (t+7+`ENC_LAT` with parity);
  - IDLE again at the next cycle.
- No back-to-back overlap: throughput is one nibble per 7+`ENC_LAT` cycles (8+`ENC_LAT` with parity).
- `tx_src` is valid whenever `tx_valid` is high.
- `ack` never coincides with `tx_valid`.

## Configuration
- `CTRL_PARITY_EN` defined:
  - a 6th bit equal to `m1^m2^m3^m4^m5` (even parity) is shifted after `m5`;
  - `tx_valid` is high for 6 cycles;
  - the shift register is 6 bits.
- `CTRL_PARITY_EN` undefined: 5-bit frames; no parity logic is present.

## Structure
- Package `ctrl_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT, SHIFT);
  - `CODE_W` = 5;
  - `FRAME_W` (5, or 6 under `CTRL_PARITY_EN`);
  - the WAIT counter width.
- Sub-module `rr_arbiter2`: inputs `req[1:0]` and last-grant pointer; outputs a one-hot grant. It is purely combinational; the pointer register lives in the parent.
- The parent contains the FSM, nibble register, WAIT counter, shift register and bit counter.

## Test plan
The bench stub encoder drives `m1..m5` = {1, a, b, c, d} one cycle after `ready`; `ENC_LAT` = 1.
- Single request: `req0` with `nib0`=0101 → `ack0` at t+1; `tx_bit` = 1,0,1,0,1 over t+3..t+7; `tx_src`=0.
- Contention: `req0` and `req1` held together (`nib0`=0001, `nib1`=1110) → grants alternate 0, 1, 0, with `ack0` first. Serial frames are 10001 then 11110.
- Back-to-back from one port: `req1` held with 4 nibbles → `ack1` pulses every 8 cycles; no gap or overlap errors.
- Reset mid-SHIFT: assert `reset` on the 3rd `tx_valid` cycle → next cycle `tx_valid`=0, `busy`=0, all outputs 0. After reset, `req0` is granted first.
- `CTRL_PARITY_EN` build: `nib0`=0011 → frame 1,0,0,1,1,1 (parity 1) with `tx_valid` high for 6 cycles.
- Sweep all 16 nibbles on `req0`: each serial frame equals {1, nibble} in order, and `a..d` match the latched nibble during ISSUE.
